// File: rtl/spi_wr_arbiter.sv
// spi_wr_arbiter: round-robin arbiter sharing one memory write port between NUM_REQ requesters
//   clk_i/arst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake into a single-entry capture buffer
//   req_address_i/req_data_i packed per-requester write address and data
//   mem_wr_en_o/mem_address_o/mem_data_o/mem_ready_i  shared memory write port
//   grant_o                 one-hot owner of the port
//   done_o/err_o            one-cycle completion / timeout-abort pulses
//   busy_o                  a write is in flight
module spi_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic                      mem_wr_en_o,
  output logic [ADDR_W-1:0]         mem_address_o,
  output logic [DATA_W-1:0]         mem_data_o,
  input  logic                      mem_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic                      busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;
  logic [NUM_REQ-1:0] pending, cap, clr;
  logic [ADDR_W-1:0] addr_buf [NUM_REQ];
  logic [DATA_W-1:0] data_buf [NUM_REQ];
  logic [IW-1:0] ptr, cur, sel;
  logic [CW-1:0] cnt;
  logic expire, fin;
  assign req_ready_o = ~pending;
  assign busy_o = state == WRITE;
  assign cap = req_valid_i & ~pending;
  assign expire = TIMEOUT != 0 && !mem_ready_i && cnt == CW'(TIMEOUT - 1);
  assign fin = state == WRITE && (mem_ready_i || expire);
  assign clr = fin ? grant_o : '0;
  // Walk downward so the pending index closest above ptr (wrapping) is the last one kept.
  always_comb begin
    sel = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (pending[IW'(j)]) sel = IW'(j);
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap[i]) begin
        addr_buf[i] <= req_address_i[i*ADDR_W +: ADDR_W];
        data_buf[i] <= req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= IDLE;
      pending       <= '0;
      grant_o       <= '0;
      done_o        <= '0;
      err_o         <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      ptr           <= '0;
      cur           <= '0;
      cnt           <= '0;
    end else begin
      pending <= (pending | cap) & ~clr;
      done_o  <= '0;
      err_o   <= '0;
      if (state == IDLE) begin
        if (|pending) begin
          state         <= WRITE;
          cur           <= sel;
          grant_o       <= NUM_REQ'(1) << sel;
          mem_wr_en_o   <= 1'b1;
          mem_address_o <= addr_buf[sel];
          mem_data_o    <= data_buf[sel];
          cnt           <= '0;
        end
      end else if (fin) begin
        // Completion wins over timeout when both happen on the same edge.
        state       <= IDLE;
        mem_wr_en_o <= 1'b0;
        grant_o     <= '0;
        done_o      <= mem_ready_i ? grant_o : '0;
        err_o       <= mem_ready_i ? '0 : grant_o;
        ptr         <= cur == IW'(NUM_REQ - 1) ? '0 : cur + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_wr_arbiter.sv
// tb_spi_wr_arbiter: table-driven and scoreboard checks of spi_wr_arbiter
module tb_spi_wr_arbiter;
  localparam int N = 2, AW = 24, DW = 32, TO = 16;
  logic clk_i = 0, arst_i = 1, mem_ready_i = 0;
  logic [N-1:0] req_valid_i = '0, req_ready_o, grant_o, done_o, err_o;
  logic [N*AW-1:0] req_address_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic mem_wr_en_o, busy_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_data_o;
  spi_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_data_i(req_data_i), .mem_wr_en_o(mem_wr_en_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    int idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int stall;
    int len;
    bit err;
  } wr_t;
  wr_t exp_q[$];
  wr_t vec[6];
  int checks = 0, errors = 0, ncomp = 0, nexp = 0, k = 0;
  logic [N-1:0] w_grant;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask
  // Monitor: drives mem_ready_i from the stall count of the write at the head of the
  // scoreboard, records what the port presented, and checks it when done/err pulses.
  always @(negedge clk_i) begin : mon
    wr_t e;
    logic [N-1:0] oh;
    if (arst_i) begin
      k = 0;
      mem_ready_i = 0;
    end else begin
      chk("pulse_onehot", 64'($onehot0({done_o, err_o})), 1);
      chk("busy_vs_wr_en", 64'(busy_o), 64'(mem_wr_en_o));
      if (done_o != 0 || err_o != 0) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 64'({done_o, err_o}), 0);
        else begin
          e = exp_q.pop_front();
          ncomp++;
          oh = N'(1) << e.idx;
          chk("grant", 64'(w_grant), 64'(oh));
          chk("address", 64'(w_addr), 64'(e.addr));
          chk("data", 64'(w_data), 64'(e.data));
          chk("wr_en_cycles", 64'(k), 64'(e.len));
          chk("done", 64'(done_o), e.err ? 0 : 64'(oh));
          chk("err", 64'(err_o), e.err ? 64'(oh) : 0);
          chk("ready_back", 64'(req_ready_o[e.idx]), 1);
        end
      end
      if (mem_wr_en_o) begin
        if (k == 0) begin
          w_grant = grant_o;
          w_addr = mem_address_o;
          w_data = mem_data_o;
        end else begin
          chk("hold_grant", 64'(grant_o), 64'(w_grant));
          chk("hold_address", 64'(mem_address_o), 64'(w_addr));
          chk("hold_data", 64'(mem_data_o), 64'(w_data));
        end
        k++;
        mem_ready_i = exp_q.size() == 0 || k > exp_q[0].stall;
      end else begin
        k = 0;
        mem_ready_i = 0;
      end
    end
  end
  task automatic send(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    while (!req_ready_o[idx] && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk("ready_wait", 64'(req_ready_o[idx]), 1);
    req_address_i[idx*AW +: AW] = a;
    req_data_i[idx*DW +: DW] = d;
    req_valid_i[idx] = 1;
    @(negedge clk_i);
    req_valid_i[idx] = 0;
  endtask
  task automatic send2(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req_address_i = {a1, a0};
    req_data_i = {d1, d0};
    req_valid_i = 2'b11;
    @(negedge clk_i);
    req_valid_i = 2'b00;
  endtask
  task automatic wait_comp(input int target);
    int t = 0;
    while (ncomp < target && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    chk("completion_count", 64'(ncomp), 64'(target));
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_wr_en"}, 64'(mem_wr_en_o), 0);
    chk({name, "_grant"}, 64'(grant_o), 0);
    chk({name, "_busy"}, 64'(busy_o), 0);
    chk({name, "_addr"}, 64'(mem_address_o), 0);
    chk({name, "_data"}, 64'(mem_data_o), 0);
    chk({name, "_ready"}, 64'(req_ready_o), 64'(2'b11));
    chk({name, "_done_err"}, 64'({done_o, err_o}), 0);
  endtask
  initial begin
    int t;
    vec[0] = '{1, 24'hABCDEF, 32'h12345678, 5, 6, 0};
    vec[1] = '{0, 24'hFFFFFF, 32'hFFFFFFFF, 15, 16, 0};
    vec[2] = '{1, 24'h000000, 32'h00000000, 16, 16, 1};
    vec[3] = '{0, 24'h123456, 32'hA5A5A5A5, 200, 16, 1};
    vec[4] = '{0, 24'h800001, 32'h00000001, 1, 2, 0};
    vec[5] = '{1, 24'h7FFFFE, 32'h5A5A5A5A, 0, 1, 0};
    repeat (2) @(negedge clk_i);
    chk_idle("reset");
    arst_i = 0;
    @(negedge clk_i);
    chk_idle("post_reset");
    // Single write and its latency
    exp_q.push_back('{0, 24'h000010, 32'hDEADBEEF, 0, 1, 0});
    send(0, 24'h000010, 32'hDEADBEEF);
    chk("lat_cap_wr_en", 64'(mem_wr_en_o), 0);
    chk("lat_cap_ready", 64'(req_ready_o), 64'(2'b10));
    @(negedge clk_i);
    chk("lat_wr_en", 64'(mem_wr_en_o), 1);
    chk("lat_grant", 64'(grant_o), 64'(2'b01));
    chk("lat_addr", 64'(mem_address_o), 64'(24'h000010));
    chk("lat_data", 64'(mem_data_o), 64'(32'hDEADBEEF));
    @(negedge clk_i);
    chk("single_wr_en_off", 64'(mem_wr_en_o), 0);
    chk("single_done", 64'(done_o), 64'(2'b01));
    chk("single_ready", 64'(req_ready_o), 64'(2'b11));
    nexp++;
    wait_comp(nexp);
    // Table: wait states, boundary, timeouts
    foreach (vec[i]) begin
      exp_q.push_back(vec[i]);
      send(vec[i].idx, vec[i].addr, vec[i].data);
      nexp++;
      wait_comp(nexp);
    end
    // Contention with pointer at 0, twice
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back('{0, 24'h000A00 + 24'(r), 32'h0A0A0000 + 32'(r), 0, 1, 0});
      exp_q.push_back('{1, 24'h000B00 + 24'(r), 32'h0B0B0000 + 32'(r), 0, 1, 0});
      send2(24'h000A00 + 24'(r), 32'h0A0A0000 + 32'(r), 24'h000B00 + 24'(r), 32'h0B0B0000 + 32'(r));
      nexp += 2;
      wait_comp(nexp);
    end
    // Fairness: req1 writing with wait states, req0 queued behind it, req1 re-requests
    exp_q.push_back('{1, 24'h111111, 32'h11111111, 3, 4, 0});
    exp_q.push_back('{0, 24'h222222, 32'h22222222, 0, 1, 0});
    exp_q.push_back('{1, 24'h333333, 32'h33333333, 0, 1, 0});
    send(1, 24'h111111, 32'h11111111);
    send(0, 24'h222222, 32'h22222222);
    send(1, 24'h333333, 32'h33333333);
    nexp += 3;
    wait_comp(nexp);
    // Timeout on req0, then req1 proceeds
    exp_q.push_back('{0, 24'h444444, 32'h44444444, 200, 16, 1});
    exp_q.push_back('{1, 24'h555555, 32'h55555555, 0, 1, 0});
    send2(24'h444444, 32'h44444444, 24'h555555, 32'h55555555);
    nexp += 2;
    wait_comp(nexp);
    // Reset in the middle of a write
    exp_q.push_back('{0, 24'h00ABCD, 32'hCAFEF00D, 200, 16, 1});
    send(0, 24'h00ABCD, 32'hCAFEF00D);
    t = 0;
    while (k < 3 && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("mid_write_reached", 64'(k >= 3), 1);
    #1 arst_i = 1;
    #1 chk_idle("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    arst_i = 0;
    @(negedge clk_i);
    chk("post_abort_pulses", 64'({done_o, err_o}), 0);
    exp_q.push_back('{1, 24'h00F00D, 32'hBEEFCAFE, 2, 3, 0});
    send(1, 24'h00F00D, 32'hBEEFCAFE);
    nexp++;
    wait_comp(nexp);
    repeat (3) @(negedge clk_i);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
